// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: valid/ready register chain of STAGES stages carrying a
// DATA_W payload at full throughput, with synchronous flush. SKID=1 puts a
// skid register in every stage so that ready_o comes straight from a flop.
module pipe_stage_chain #(
    parameter  int DATA_W = 32,
    parameter  int STAGES = 1,
    parameter  int SKID   = 0,
    localparam int CNT_W  = $clog2(STAGES*(1+SKID)+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ready_i,
    output logic [CNT_W-1:0]  occupancy_o
);

    // Index k is the boundary in front of stage k; index STAGES is the output port.
    logic              w_vld [STAGES+1];
    logic [DATA_W-1:0] w_dat [STAGES+1];
    logic              w_rdy [STAGES+1];

    logic              w_in_xfer;
    logic              w_out_xfer;
    logic [CNT_W-1:0]  r_occ;

    assign w_vld[0]      = valid_i;
    assign w_dat[0]      = data_i;
    assign w_rdy[STAGES] = ready_i;

    assign ready_o = w_rdy[0];
    assign valid_o = w_vld[STAGES];
    assign data_o  = w_dat[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (SKID == 0) begin : g_pass
            logic              r_main_vld;
            logic [DATA_W-1:0] r_main_dat;
            logic              w_cke;

            // A stage may load whenever it is empty or its content is leaving.
            assign w_cke    = ~r_main_vld | w_rdy[k+1];
            assign w_rdy[k] = w_cke;

            // Main register: take whatever the upstream side presents on cke.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_main_vld <= 1'b0;
                    r_main_dat <= '0;
                end else if (flush_i) begin
                    r_main_vld <= 1'b0;
                end else if (w_cke) begin
                    r_main_vld <= w_vld[k];
                    r_main_dat <= w_dat[k];
                end
            end

            assign w_vld[k+1] = r_main_vld;
            assign w_dat[k+1] = r_main_dat;
        end else begin : g_skid
            logic              r_main_vld;
            logic [DATA_W-1:0] r_main_dat;
            logic              r_skid_vld;
            logic [DATA_W-1:0] r_skid_dat;
            logic              w_up_xfer;

            // Upstream ready is purely the skid-empty flop, isolating ready_i.
            assign w_rdy[k]  = ~r_skid_vld;
            assign w_up_xfer = w_vld[k] & ~r_skid_vld;

            // Main/skid pair: skid catches the item that arrives while main is stalled,
            // and is always drained into main before any newer upstream item.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_main_vld <= 1'b0;
                    r_main_dat <= '0;
                    r_skid_vld <= 1'b0;
                    r_skid_dat <= '0;
                end else if (flush_i) begin
                    r_main_vld <= 1'b0;
                    r_skid_vld <= 1'b0;
                end else if (~r_main_vld | w_rdy[k+1]) begin
                    if (r_skid_vld) begin
                        r_main_vld <= 1'b1;
                        r_main_dat <= r_skid_dat;
                        r_skid_vld <= 1'b0;
                    end else begin
                        r_main_vld <= w_up_xfer;
                        if (w_up_xfer) begin
                            r_main_dat <= w_dat[k];
                        end
                    end
                end else if (w_up_xfer) begin
                    r_skid_vld <= 1'b1;
                    r_skid_dat <= w_dat[k];
                end
            end

            assign w_vld[k+1] = r_main_vld;
            assign w_dat[k+1] = r_main_dat;
        end
    end

    assign w_in_xfer  = valid_i & w_rdy[0];
    assign w_out_xfer = w_vld[STAGES] & ready_i;

    // Occupancy: net change of port transfers; flush empties the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (flush_i) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + CNT_W'(w_in_xfer) - CNT_W'(w_out_xfer);
        end
    end

    assign occupancy_o = r_occ;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: one SKID=0 (3 stages) and one SKID=1 (2 stages)
// instance, table-driven directed vectors plus a random scoreboard run and an
// asynchronous mid-stream reset.
module tb_pipe_stage_chain;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: STAGES=3, SKID=0
    logic        fl0 = 1'b0, vi0 = 1'b0, ri0 = 1'b1;
    logic [31:0] di0 = '0;
    logic        ro0, vo0;
    logic [31:0] do0;
    logic [1:0]  oc0;

    // Instance 1: STAGES=2, SKID=1
    logic        fl1 = 1'b0, vi1 = 1'b0, ri1 = 1'b1;
    logic [31:0] di1 = '0;
    logic        ro1, vo1;
    logic [31:0] do1;
    logic [2:0]  oc1;

    pipe_stage_chain #(.DATA_W(32), .STAGES(3), .SKID(0)) u0 (
        .clk(clk), .rst(rst), .flush_i(fl0), .valid_i(vi0), .data_i(di0),
        .ready_o(ro0), .valid_o(vo0), .data_o(do0), .ready_i(ri0),
        .occupancy_o(oc0)
    );

    pipe_stage_chain #(.DATA_W(32), .STAGES(2), .SKID(1)) u1 (
        .clk(clk), .rst(rst), .flush_i(fl1), .valid_i(vi1), .data_i(di1),
        .ready_o(ro1), .valid_o(vo1), .data_o(do1), .ready_i(ri1),
        .occupancy_o(oc1)
    );

    typedef struct {
        logic        fl;
        logic        vi;
        logic [31:0] di;
        logic        ri;
        logic        evo;
        logic [31:0] edo;
        int          eocc;
        logic        erdy;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    function automatic vec_t mk(input logic fl, input logic vi, input logic [31:0] di,
                                input logic ri, input logic evo, input logic [31:0] edo,
                                input int eocc, input logic erdy);
        vec_t v;
        v.fl = fl; v.vi = vi; v.di = di; v.ri = ri;
        v.evo = evo; v.edo = edo; v.eocc = eocc; v.erdy = erdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one row, clock it, then compare registered outputs with the row still applied.
    task automatic apply(input int sel, input vec_t v, input int idx);
        logic        av, ar;
        logic [31:0] ad, ao;
        if (sel == 0) begin
            fl0 = v.fl; vi0 = v.vi; di0 = v.di; ri0 = v.ri;
        end else begin
            fl1 = v.fl; vi1 = v.vi; di1 = v.di; ri1 = v.ri;
        end
        @(posedge clk); #1;
        if (sel == 0) begin
            av = vo0; ad = do0; ao = 32'(oc0); ar = ro0;
        end else begin
            av = vo1; ad = do1; ao = 32'(oc1); ar = ro1;
        end
        chk($sformatf("dut%0d row%0d valid_o", sel, idx), 32'(av), 32'(v.evo));
        if (v.evo) chk($sformatf("dut%0d row%0d data_o", sel, idx), ad, v.edo);
        chk($sformatf("dut%0d row%0d occupancy_o", sel, idx), ao, 32'(v.eocc));
        chk($sformatf("dut%0d row%0d ready_o", sel, idx), 32'(ar), 32'(v.erdy));
    endtask

    // One random-test cycle on instance 1 with a mid-cycle ready_i glitch and scoreboard.
    task automatic cyc1(input logic vi, input logic [31:0] di, input logic ri);
        logic        r_before;
        logic [31:0] exp;
        vi1 = vi; di1 = di; ri1 = ri;
        #2;
        r_before = ro1;
        ri1 = ~ri1;
        #1;
        chk("ready_glitch", 32'(ro1), 32'(r_before));
        ri1 = ~ri1;
        #1;
        if (vo1 && ri1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_underflow: got %0h expected none", do1);
            end else begin
                exp = sb.pop_front();
                chk("stream_order", do1, exp);
            end
        end
        if (vi1 && ro1) sb.push_back(di1);
        @(posedge clk); #1;
    endtask

    vec_t tab0[24];
    vec_t tab1[14];

    initial begin
        // Instance 0: stream, backpressure through pass-through ready, flush.
        for (int i = 0; i < 8; i++) begin
            tab0[i] = mk(0, 1, 32'(i + 1), 1, (i >= 2), 32'(i - 1), (i >= 2) ? 3 : i + 1, 1);
        end
        tab0[8]  = mk(0, 0, 0, 1, 1, 32'h7, 2, 1);
        tab0[9]  = mk(0, 0, 0, 1, 1, 32'h8, 1, 1);
        tab0[10] = mk(0, 0, 0, 1, 0, 0, 0, 1);
        tab0[11] = mk(0, 1, 32'h11, 0, 0, 0, 1, 1);
        tab0[12] = mk(0, 1, 32'h12, 0, 0, 0, 2, 1);
        tab0[13] = mk(0, 1, 32'h13, 0, 1, 32'h11, 3, 0);
        tab0[14] = mk(0, 1, 32'h14, 0, 1, 32'h11, 3, 0);
        tab0[15] = mk(0, 0, 0, 1, 1, 32'h12, 2, 1);
        tab0[16] = mk(0, 0, 0, 1, 1, 32'h13, 1, 1);
        tab0[17] = mk(0, 0, 0, 1, 0, 0, 0, 1);
        tab0[18] = mk(0, 1, 32'h21, 1, 0, 0, 1, 1);
        tab0[19] = mk(0, 1, 32'h22, 1, 0, 0, 2, 1);
        tab0[20] = mk(1, 1, 32'h23, 1, 0, 0, 0, 1);
        tab0[21] = mk(0, 0, 0, 1, 0, 0, 0, 1);
        tab0[22] = mk(0, 0, 0, 1, 0, 0, 0, 1);
        tab0[23] = mk(0, 0, 0, 1, 0, 0, 0, 1);

        // Instance 1: skid absorption, in-order release, flush.
        tab1[0]  = mk(0, 1, 32'hA0, 0, 0, 0, 1, 1);
        tab1[1]  = mk(0, 1, 32'hA1, 0, 1, 32'hA0, 2, 1);
        tab1[2]  = mk(0, 1, 32'hA2, 0, 1, 32'hA0, 3, 1);
        tab1[3]  = mk(0, 1, 32'hA3, 0, 1, 32'hA0, 4, 0);
        tab1[4]  = mk(0, 1, 32'hA4, 0, 1, 32'hA0, 4, 0);
        tab1[5]  = mk(0, 1, 32'hA4, 1, 1, 32'hA1, 3, 0);
        tab1[6]  = mk(0, 1, 32'hA4, 1, 1, 32'hA2, 2, 1);
        tab1[7]  = mk(0, 1, 32'hA4, 1, 1, 32'hA3, 2, 1);
        tab1[8]  = mk(0, 0, 0, 1, 1, 32'hA4, 1, 1);
        tab1[9]  = mk(0, 0, 0, 1, 0, 0, 0, 1);
        tab1[10] = mk(0, 1, 32'hB0, 0, 0, 0, 1, 1);
        tab1[11] = mk(0, 1, 32'hB1, 0, 1, 32'hB0, 2, 1);
        tab1[12] = mk(1, 1, 32'hB2, 0, 0, 0, 0, 1);
        tab1[13] = mk(0, 0, 0, 1, 0, 0, 0, 1);

        // Reset values with reset held, then release.
        #12;
        chk("rst ready_o0", 32'(ro0), 32'h1);
        chk("rst ready_o1", 32'(ro1), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst valid_o0", 32'(vo0), 32'h0);
        chk("rst data_o0", do0, 32'h0);
        chk("rst occ0", 32'(oc0), 32'h0);
        chk("rst valid_o1", 32'(vo1), 32'h0);
        chk("rst data_o1", do1, 32'h0);
        chk("rst occ1", 32'(oc1), 32'h0);

        for (int i = 0; i < 24; i++) apply(0, tab0[i], i);
        fl0 = 1'b0; vi0 = 1'b0; ri0 = 1'b1;
        for (int i = 0; i < 14; i++) apply(1, tab1[i], i);
        fl1 = 1'b0; vi1 = 1'b0; ri1 = 1'b1;

        // Random valid/ready on the skid chain, then drain.
        for (int n = 0; n < 2000; n++) begin
            cyc1(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 8; n++) cyc1(1'b0, 32'h0, 1'b1);
        chk("drain scoreboard_empty", 32'(sb.size()), 32'h0);
        chk("drain occ1", 32'(oc1), 32'h0);

        // Asynchronous reset mid-stream with downstream stalled.
        ri1 = 1'b0;
        for (int n = 0; n < 3; n++) begin
            vi1 = 1'b1; di1 = 32'hC0 + 32'(n);
            @(posedge clk); #1;
        end
        vi1 = 1'b0;
        vi0 = 1'b1; di0 = 32'h55; ri0 = 1'b0;
        @(posedge clk); #1;
        chk("pre-areset occ1", 32'(oc1), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        chk("areset valid_o1", 32'(vo1), 32'h0);
        chk("areset data_o1", do1, 32'h0);
        chk("areset occ1", 32'(oc1), 32'h0);
        chk("areset valid_o0", 32'(vo0), 32'h0);
        chk("areset data_o0", do0, 32'h0);
        chk("areset occ0", 32'(oc0), 32'h0);
        vi0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post-areset ready_o1", 32'(ro1), 32'h1);
        chk("post-areset ready_o0", 32'(ro0), 32'h1);
        chk("post-areset valid_o1", 32'(vo1), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
